vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Display stage downstream of the dual-port framebuffer. Generates 640x480@60 VGA timing on the pixel clock.
//  Drives the framebuffer read port (addr_out) and absorbs its 1-cycle registered read latency.
//  Maps the 2-bit Game Boy shade to 12-bit RGB; the 160x144 image is pixel-replicated and centred, with a border colour around it.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL=800)
//  V_ACTIVE 480  visible lines;        V_FP 10, V_SYNC 2,  V_BP 33 (V_TOTAL=525)
//  SYNC_POL  0    sync active level (0 = active-low)
//  IMG_W 160, IMG_H 144   source image size in framebuffer pixels
//  FB_W      256  framebuffer row stride; address = fy*FB_W + fx
//  B         8    framebuffer bits/pixel; only data[1:0] used
//  SCALE_LOG2 1   replication factor 2^SCALE_LOG2 (default 2x -> 320x288)
//  X0 160, Y0 96  window origin in screen pixels/lines
//  BORDER 12'h000 RGB outside the window
//  PAL0..PAL3 12'hFFF,12'hAAA,12'h555,12'h000  shade 0..3 -> RGB444
// PORTS
//  clk_in    in  1   pixel clock (25.175 MHz nominal); also the framebuffer clk_out
//  rst       in  1   synchronous, active-high reset
//  fb_addr   out 16  framebuffer read address (-> addr_out)
//  fb_data   in  B   framebuffer read data (<- data_out), valid 1 cycle after fb_addr
//  rgb       out 12  {R[3:0],G[3:0],B[3:0]}, 0 when de=0
//  hsync     out 1   horizontal sync
//  vsync     out 1   vertical sync
//  de        out 1   display enable (active area)
//  frame_start out 1 1-cycle pulse, aligned with the first active pixel of a frame at the outputs
// BEHAVIOUR
//  Reset: hc=vc=0. rgb=0, de=0, frame_start=0, fb_addr=0; hsync and vsync at the inactive level (!SYNC_POL).
//   The pipeline is flushed; outputs stay at reset values until valid data reaches stage 3.
//   Reset asserted mid-frame restarts at hc=vc=0 on the next cycle.
//  Counters: hc 0..H_TOTAL-1. At hc=H_TOTAL-1, hc->0 and vc increments; at vc=V_TOTAL-1 with that wrap, vc->0.
//  Raw timing at counter stage (cycle n):
//   de_r = hc<H_ACTIVE && vc<V_ACTIVE
//   hs_r active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 by default)
//   vs_r active for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491 by default)
//   win_r = X0<=hc<X0+(IMG_W<<S) && Y0<=vc<Y0+(IMG_H<<S)
//  Address (registered, valid cycle n+1):
//   fx=(hc-X0)>>S, fy=(vc-Y0)>>S, fb_addr = fy*FB_W + fx, truncated to 16 bits.
//   Outside the window fb_addr holds its previous value.
//   Implementation may use incremental counters instead of a multiply; the result must be identical.
//  Data returns cycle n+2. The output register at n+3 sets rgb = de ? (win ? PAL[fb_data[1:0]] : BORDER) : 0.
//  hsync, vsync, de, win, frame_start are delayed 3 stages so every output is aligned; latency counter->pins = 3.
//  frame_start_r = (hc==0 && vc==0).
//  Boundaries:
//   window edges are exact: hc=X0 is the first image pixel, hc=X0+319 the last.
//   Each fb pixel is repeated 2^S columns and 2^S lines.
//   Counter wrap and line wrap in the same cycle (last pixel of frame) -> hc=0, vc=0.
// STRUCTURE
//  Include file vga_defs.vh: timing localparams, H_TOTAL/V_TOTAL, default palette constants.
//  Sub-module vga_timing: hc/vc counters plus de_r/hs_r/vs_r/frame_start_r, reset to 0.
//  vga_scanout: instantiates vga_timing and adds the window/address/palette pipeline.
// TESTING
//  1 Reset 3 cycles then release -> de=0, hsync=vsync=1, rgb=0. First de=1 at cycle 3 after release; frame_start high that cycle only.
//  2 Free-run 2 frames -> hsync low 96 clocks starting at hc 656 (+3). Period 800 clocks; vsync low 2 lines; 420000 clocks/frame.
//  3 Framebuffer model with mem[a]=a[1:0] (1-cycle read latency) -> at hc=160,vc=96: fb_addr=0. Pixels 160,161 use shade 0 -> FFF; pixels 162,163 use shade 1 -> AAA.
//  4 Line vc=97 re-reads row 0 and line 98 reads row 1 -> fb_addr=256 at hc=160 (+1 cycle).
//   Last image pixel hc=479,vc=383 -> fb_addr=143*256+159=36767.
//  5 hc=159 and hc=480 inside active area -> rgb=BORDER. Blanking -> rgb=0 and fb_data ignored.
//  6 Assert rst for 1 cycle at hc=300,vc=200 -> all outputs at reset values 1 cycle later; timing restarts at hc=vc=0.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// Shared constants, default timing/palette values and pipeline types for the
// 640x480@60 Game Boy scanout stage.
package vga_scanout_pkg;

    localparam int CNT_W       = 12;
    localparam int ADDR_W      = 16;
    localparam int RGB_W       = 12;
    localparam int PIPE_STAGES = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [RGB_W-1:0] DEF_BORDER = 12'h000;
    localparam logic [RGB_W-1:0] DEF_PAL0   = 12'hFFF;
    localparam logic [RGB_W-1:0] DEF_PAL1   = 12'hAAA;
    localparam logic [RGB_W-1:0] DEF_PAL2   = 12'h555;
    localparam logic [RGB_W-1:0] DEF_PAL3   = 12'h000;

    // Per-pixel control bits carried alongside the framebuffer read.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic win;
        logic fs;
    } vga_ctl_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus video output pins of the scanout stage.
interface vga_scanout_if #(
    parameter int B = 8
);
    logic [15:0]  fb_addr;
    logic [B-1:0] fb_data;
    logic [11:0]  rgb;
    logic         hsync;
    logic         vsync;
    logic         de;
    logic         frame_start;

    modport master (
        output fb_addr,
        input  fb_data,
        output rgb,
        output hsync,
        output vsync,
        output de,
        output frame_start
    );

    modport slave (
        input  fb_addr,
        output fb_data,
        input  rgb,
        input  hsync,
        input  vsync,
        input  de,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters and the raw (unpipelined) timing decodes.
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_in,
    input  logic             rst,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             de_r,
    output logic             hs_r,
    output logic             vs_r,
    output logic             fs_r
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    logic [CNT_W-1:0] hc_reg;
    logic [CNT_W-1:0] vc_reg;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else if (hc_reg == CNT_W'(H_TOTAL - 1)) begin
            hc_reg <= '0;
            vc_reg <= (vc_reg == CNT_W'(V_TOTAL - 1)) ? '0 : vc_reg + 1'b1;
        end else begin
            hc_reg <= hc_reg + 1'b1;
        end
    end

    assign hc   = hc_reg;
    assign vc   = vc_reg;
    assign de_r = (hc_reg < CNT_W'(H_ACTIVE)) && (vc_reg < CNT_W'(V_ACTIVE));
    assign hs_r = (hc_reg >= CNT_W'(HS_BEG)) && (hc_reg < CNT_W'(HS_END));
    assign vs_r = (vc_reg >= CNT_W'(VS_BEG)) && (vc_reg < CNT_W'(VS_END));
    assign fs_r = (hc_reg == '0) && (vc_reg == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: timing, windowed framebuffer addressing with 2^S replication,
// and shade-to-RGB palette; every output lags the counters by three cycles.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int               H_ACTIVE   = DEF_H_ACTIVE,
    parameter int               H_FP       = DEF_H_FP,
    parameter int               H_SYNC     = DEF_H_SYNC,
    parameter int               H_BP       = DEF_H_BP,
    parameter int               V_ACTIVE   = DEF_V_ACTIVE,
    parameter int               V_FP       = DEF_V_FP,
    parameter int               V_SYNC     = DEF_V_SYNC,
    parameter int               V_BP       = DEF_V_BP,
    parameter logic             SYNC_POL   = 1'b0,
    parameter int               IMG_W      = 160,
    parameter int               IMG_H      = 144,
    parameter int               FB_W       = 256,
    parameter int               B          = 8,
    parameter int               SCALE_LOG2 = 1,
    parameter int               X0         = 160,
    parameter int               Y0         = 96,
    parameter logic [RGB_W-1:0] BORDER     = DEF_BORDER,
    parameter logic [RGB_W-1:0] PAL0       = DEF_PAL0,
    parameter logic [RGB_W-1:0] PAL1       = DEF_PAL1,
    parameter logic [RGB_W-1:0] PAL2       = DEF_PAL2,
    parameter logic [RGB_W-1:0] PAL3       = DEF_PAL3
) (
    input logic           clk_in,
    input logic           rst,
    vga_scanout_if.master vif
);

    localparam int X1 = X0 + (IMG_W << SCALE_LOG2);
    localparam int Y1 = Y0 + (IMG_H << SCALE_LOG2);
    localparam logic [4*RGB_W-1:0] PAL_VEC = {PAL3, PAL2, PAL1, PAL0};

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             de_r;
    logic             hs_r;
    logic             vs_r;
    logic             fs_r;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_in (clk_in),
        .rst    (rst),
        .hc     (hc),
        .vc     (vc),
        .de_r   (de_r),
        .hs_r   (hs_r),
        .vs_r   (vs_r),
        .fs_r   (fs_r)
    );

    // Stage 0: window decode and framebuffer address (counter cycle).
    logic             win_r;
    logic [CNT_W-1:0] hx;
    logic [CNT_W-1:0] vy;
    logic [CNT_W-1:0] fx;
    logic [CNT_W-1:0] fy;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic [ADDR_W-1:0] fb_addr_next;
    vga_ctl_t         ctl_r;

    assign win_r = (hc >= CNT_W'(X0)) && (hc < CNT_W'(X1)) &&
                   (vc >= CNT_W'(Y0)) && (vc < CNT_W'(Y1));
    assign hx    = hc - CNT_W'(X0);
    assign vy    = vc - CNT_W'(Y0);
    assign fx    = hx >> SCALE_LOG2;
    assign fy    = vy >> SCALE_LOG2;

    always_comb begin
        fb_addr_next = fb_addr_reg;
        if (win_r) begin
            fb_addr_next = ADDR_W'(fy) * ADDR_W'(FB_W) + ADDR_W'(fx);
        end
    end

    assign ctl_r = '{de: de_r, hs: hs_r, vs: vs_r, win: win_r, fs: fs_r};

    // Control bits ride two stages so they meet the read data returned by the framebuffer.
    vga_ctl_t ctl_pipe [PIPE_STAGES];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            fb_addr_reg <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                ctl_pipe[i] <= '0;
            end
        end else begin
            fb_addr_reg <= fb_addr_next;
            ctl_pipe[0] <= ctl_r;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign vif.fb_addr = fb_addr_reg;

    // Palette table built from the packed parameter vector.
    logic [RGB_W-1:0] pal_tab [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pal
            assign pal_tab[gi] = PAL_VEC[gi*RGB_W +: RGB_W];
        end
    endgenerate

    logic [RGB_W-1:0] pix_rgb;
    vga_ctl_t         ctl_last;

    assign ctl_last = ctl_pipe[PIPE_STAGES-1];
    assign pix_rgb  = pal_tab[vif.fb_data[1:0]];

    logic             unused_fb_bits;
    assign unused_fb_bits = &{1'b0, vif.fb_data[B-1:2]};

    // Output stage.
    logic [RGB_W-1:0] rgb_reg;
    logic             hsync_reg;
    logic             vsync_reg;
    logic             de_reg;
    logic             fs_reg;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rgb_reg   <= '0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
            de_reg    <= 1'b0;
            fs_reg    <= 1'b0;
        end else begin
            rgb_reg   <= ctl_last.de ? (ctl_last.win ? pix_rgb : BORDER) : '0;
            hsync_reg <= sync_level(ctl_last.hs, SYNC_POL);
            vsync_reg <= sync_level(ctl_last.vs, SYNC_POL);
            de_reg    <= ctl_last.de;
            fs_reg    <= ctl_last.fs;
        end
    end

    assign vif.rgb         = rgb_reg;
    assign vif.hsync       = hsync_reg;
    assign vif.vsync       = vsync_reg;
    assign vif.de          = de_reg;
    assign vif.frame_start = fs_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default horizontal timing, shortened vertical
// timing and window so a full frame fits a short run; non-black border.
module tb_vga_scanout;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_in = ~clk_in;

    vga_scanout_if #(.B(8)) vif ();

    vga_scanout #(
        .V_ACTIVE (48),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .IMG_H    (16),
        .Y0       (4),
        .BORDER   (12'h00F)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .vif    (vif)
    );

    // Framebuffer model: mem[a] = a[1:0], one-cycle registered read.
    always @(posedge clk_in) vif.fb_data <= {6'd0, vif.fb_addr[1:0]};

    // Number of rising edges since reset was released.
    int cyc;
    always @(posedge clk_in) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cyc %0d)", tag, got, cyc);
        end
    endtask

    task automatic goto(input int k);
        if (cyc > k) check_val("goto_late", cyc, k);
        while (cyc < k) @(negedge clk_in);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_de"},    vif.de,          1'b0);
        check_val({pfx, "_hsync"}, vif.hsync,       1'b1);
        check_val({pfx, "_vsync"}, vif.vsync,       1'b1);
        check_val({pfx, "_rgb"},   vif.rgb,         12'h000);
        check_val({pfx, "_addr"},  vif.fb_addr,     16'd0);
        check_val({pfx, "_fs"},    vif.frame_start, 1'b0);
    endtask

    initial begin
        int lows, first_low, last_low, de_last;

        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("rst");
        rst = 1'b0;

        // First pixel reaches the pins three edges after release.
        goto(2);  check_val("pre_de", vif.de, 1'b0);
        goto(3);  check_val("first_de", vif.de, 1'b1);
                  check_val("first_fs", vif.frame_start, 1'b1);
                  check_val("first_rgb_border", vif.rgb, 12'h00F);
        goto(4);  check_val("fs_one_cycle", vif.frame_start, 1'b0);

        lows = 0; first_low = -1; last_low = -1; de_last = -1;
        for (int k = 5; k <= 802; k++) begin
            goto(k);
            if (!vif.hsync) begin
                lows++;
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (vif.de) de_last = k;
        end
        check_val("hsync_width", lows, 96);
        check_val("hsync_first", first_low, 659);
        check_val("hsync_last", last_low, 754);
        check_val("de_last_line0", de_last, 642);

        goto(1458); check_val("line1_hs_pre", vif.hsync, 1'b1);
        goto(1459); check_val("line1_hs_start", vif.hsync, 1'b0);

        // Window row vc=4 (first image line).
        goto(3361); check_val("addr_origin", vif.fb_addr, 16'd0);
        goto(3362); check_val("rgb_hc159", vif.rgb, 12'h00F);
        goto(3363); check_val("rgb_hc160", vif.rgb, 12'hFFF);
        goto(3364); check_val("rgb_hc161", vif.rgb, 12'hFFF);
        goto(3365); check_val("rgb_hc162", vif.rgb, 12'hAAA);
        goto(3366); check_val("rgb_hc163", vif.rgb, 12'hAAA);
        goto(3367); check_val("rgb_hc164", vif.rgb, 12'h555);
        goto(3680); check_val("addr_hc479", vif.fb_addr, 16'd159);
        goto(3681); check_val("addr_hold", vif.fb_addr, 16'd159);
        goto(3682); check_val("rgb_hc479", vif.rgb, 12'h000);
        goto(3683); check_val("rgb_hc480", vif.rgb, 12'h00F);
        goto(3903); check_val("blank_rgb", vif.rgb, 12'h000);
                    check_val("blank_de", vif.de, 1'b0);

        // Line replication: vc=5 repeats row 0, vc=6 reads row 1.
        goto(4161); check_val("addr_vc5", vif.fb_addr, 16'd0);
        goto(4961); check_val("addr_vc6", vif.fb_addr, 16'd256);
        goto(4963); check_val("rgb_vc6_hc160", vif.rgb, 12'hFFF);
        goto(4965); check_val("rgb_vc6_hc162", vif.rgb, 12'hAAA);

        goto(28480); check_val("addr_last", vif.fb_addr, 16'd3999);
        goto(28961); check_val("addr_below_hold", vif.fb_addr, 16'd3999);
        goto(28963); check_val("rgb_below", vif.rgb, 12'h00F);
        goto(32303); check_val("rgb_vc40", vif.rgb, 12'h00F);
        goto(38403); check_val("vblank_de", vif.de, 1'b0);
                     check_val("vblank_rgb", vif.rgb, 12'h000);

        goto(40002); check_val("vs_pre", vif.vsync, 1'b1);
        goto(40003); check_val("vs_start", vif.vsync, 1'b0);
        goto(41602); check_val("vs_end", vif.vsync, 1'b0);
        goto(41603); check_val("vs_after", vif.vsync, 1'b1);
        goto(44002); check_val("fs_pre", vif.frame_start, 1'b0);
        goto(44003); check_val("fs_frame2", vif.frame_start, 1'b1);

        // Mid-frame reset at hc=300, vc=20 of frame 2.
        goto(60300); check_val("pre_rst_rgb", vif.rgb, 12'hFFF);
        rst = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("midrst");
        rst = 1'b0;
        goto(2); check_val("restart_pre_de", vif.de, 1'b0);
        goto(3); check_val("restart_de", vif.de, 1'b1);
                 check_val("restart_fs", vif.frame_start, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
